// File: rtl/onehot_key_capture.sv
// onehot_key_capture: synchronises and debounces eight raw key lines.
// Each clean single-key press is presented as a registered one-hot vector
// with a one-cycle valid strobe. Multi-key chords are flagged and dropped,
// so the downstream 8-to-3 encoder only ever sees legal one-hot input.

// Two-flop synchroniser for one raw key line.
module onehot_key_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic s1_q, s2_q;

  // Two-stage metastability filter; both stages clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;
endmodule

module onehot_key_capture #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_raw,
  output logic [7:0] onehot,
  output logic       valid,
  output logic       multi_err,
  output logic       busy,
  output logic [7:0] press_cnt
);
  localparam int NUM_LANES = 8;
  // Counter value at which the candidate vector has been stable long enough.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_e;

  logic [NUM_LANES-1:0] s2;
  logic [NUM_LANES-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_LANES-1:0] deb_q, deb_d;

  state_e               state_q, state_d;
  logic [NUM_LANES-1:0] onehot_q, onehot_d;
  logic                 valid_q, valid_d;
  logic                 merr_q, merr_d;
  logic [7:0]           pcnt_q, pcnt_d;
  logic                 deb_single;

  // Per-lane synchronisers.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_sync
    onehot_key_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (key_raw[l]),
      .q_o (s2[l])
    );
  end

  // Shared debounce: any bit change restarts the count for the whole
  // vector; once saturated the candidate is copied into deb every cycle.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    if (s2 != cand_q) begin
      cand_d = s2;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      deb_d = cand_q;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= '0;
      cnt_q  <= '0;
      deb_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
    end
  end

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign deb_single = (deb_q != '0) && ((deb_q & (deb_q - 1'b1)) == '0);

  // Press FSM: an event fires only on the IDLE->HELD transition, so a
  // new press needs a full debounced release first.
  always_comb begin
    state_d  = state_q;
    onehot_d = onehot_q;
    valid_d  = 1'b0;
    merr_d   = 1'b0;
    pcnt_d   = pcnt_q;
    case (state_q)
      IDLE: begin
        if (deb_q != '0) begin
          state_d = HELD;
          if (deb_single) begin
            onehot_d = deb_q;
            valid_d  = 1'b1;
            pcnt_d   = pcnt_q + 8'd1;
          end else begin
            merr_d = 1'b1;
          end
        end
      end
      HELD: begin
        if (deb_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      merr_q   <= 1'b0;
      pcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      merr_q   <= merr_d;
      pcnt_q   <= pcnt_d;
    end
  end

  assign onehot    = onehot_q;
  assign valid     = valid_q;
  assign multi_err = merr_q;
  assign busy      = (state_q == HELD);
  assign press_cnt = pcnt_q;
endmodule

// File: tb/tb_onehot_key_capture.sv
// Bench for onehot_key_capture with DEBOUNCE_CYCLES=4: directed latency and
// corner sequences, a table of press patterns, and a randomized run checked
// every cycle against a run-length reference model.
module tb_onehot_key_capture;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] key_raw = 8'h00;
  logic [7:0] onehot, press_cnt;
  logic       valid, multi_err, busy;

  int checks = 0;
  int errors = 0;
  int nval = 0;
  int nmerr = 0;
  bit chk_en = 1'b0;

  onehot_key_capture #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_raw   (key_raw),
    .onehot    (onehot),
    .valid     (valid),
    .multi_err (multi_err),
    .busy      (busy),
    .press_cnt (press_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: deb takes a value once the two-clock-delayed raw
  // stream has shown it on D+1 consecutive edges; events fire on the first
  // nonzero deb after a fully released (zero) deb.
  logic [7:0] hist[$];
  logic [7:0] m_runval, m_deb, m_onehot, m_pcnt;
  int         m_runlen;
  bit         m_held, m_valid, m_merr;

  always @(posedge clk) begin
    logic [7:0] s2v;
    if (rst) begin
      hist.delete();
      m_runval = 8'h00; m_runlen = 0; m_deb = 8'h00;
      m_held = 1'b0; m_valid = 1'b0; m_merr = 1'b0;
      m_onehot = 8'h00; m_pcnt = 8'h00;
    end else begin
      s2v = (hist.size() >= 2) ? hist[1] : 8'h00;
      hist.push_front(key_raw);
      if (hist.size() > 2) void'(hist.pop_back());
      m_valid = 1'b0;
      m_merr  = 1'b0;
      if (!m_held) begin
        if (m_deb != 8'h00) begin
          m_held = 1'b1;
          if ($countones(m_deb) == 1) begin
            m_onehot = m_deb;
            m_valid  = 1'b1;
            m_pcnt   = m_pcnt + 8'd1;
          end else begin
            m_merr = 1'b1;
          end
        end
      end else if (m_deb == 8'h00) begin
        m_held = 1'b0;
      end
      if (s2v == m_runval) m_runlen++;
      else begin m_runval = s2v; m_runlen = 1; end
      if (m_runlen >= D + 1) m_deb = m_runval;
    end
  end

  // Per-cycle comparison against the model, plus pulse counters.
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_valid", {31'd0, valid}, {31'd0, m_valid});
      check("m_merr", {31'd0, multi_err}, {31'd0, m_merr});
      check("m_busy", {31'd0, busy}, {31'd0, m_held});
      check("m_onehot", {24'd0, onehot}, {24'd0, m_onehot});
      check("m_pcnt", {24'd0, press_cnt}, {24'd0, m_pcnt});
      if (valid && multi_err) check("excl", 32'd1, 32'd0);
      if (valid) nval++;
      if (multi_err) nmerr++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply(input logic [7:0] v, input int n);
    key_raw = v;
    tick(n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] raw;
    int         hold;
    int         exp_val;
    int         exp_merr;
    logic [7:0] exp_onehot;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [9:0] vpat;
    int v0, m0;
    logic [7:0] prev;

    vecs[0] = '{8'h04, 12, 1, 0, 8'h04};
    vecs[1] = '{8'h03, 12, 0, 1, 8'h04};
    vecs[2] = '{8'h01,  3, 0, 0, 8'h04};
    vecs[3] = '{8'h01,  5, 1, 0, 8'h01};  // D+1 raw cycles: just accepted
    vecs[4] = '{8'h02,  4, 0, 0, 8'h01};  // D raw cycles: filtered
    vecs[5] = '{8'h80, 20, 1, 0, 8'h80};
    vecs[6] = '{8'hFF, 20, 0, 1, 8'h80};
    vecs[7] = '{8'h00,  5, 0, 0, 8'h80};

    tick(1);
    do_reset();
    chk_en = 1'b1;
    check("rst_outs", {15'd0, onehot, valid, multi_err, busy, press_cnt}, 32'd0);

    // Latency: first sampling edge is edge 1, valid after edge D+4.
    key_raw = 8'h04;
    vpat = '0;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      vpat[i] = valid;
    end
    check("lat_valid", {22'd0, vpat}, 32'h100);
    check("lat_onehot", {24'd0, onehot}, 32'h04);
    check("lat_pcnt", {24'd0, press_cnt}, 32'd1);
    check("lat_busy", {31'd0, busy}, 32'd1);
    apply(8'h00, 12);
    check("rel_busy", {31'd0, busy}, 32'd0);

    // Dropout mid-press, then a 4-clock glitch from IDLE.
    v0 = nval;
    apply(8'h10, 4); apply(8'h00, 3); apply(8'h10, 12);
    check("drop_nval", nval - v0, 1);
    check("drop_onehot", {24'd0, onehot}, 32'h10);
    apply(8'h00, 12);
    v0 = nval;
    apply(8'h01, 4); apply(8'h00, 12);
    check("glitch_nval", nval - v0, 0);
    check("glitch_onehot", {24'd0, onehot}, 32'h10);

    // Chord rejected.
    v0 = nval; m0 = nmerr;
    apply(8'h41, 12);
    check("chord_merr", nmerr - m0, 1);
    check("chord_nval", nval - v0, 0);
    check("chord_onehot", {24'd0, onehot}, 32'h10);
    check("chord_pcnt", {24'd0, press_cnt}, 32'd2);
    apply(8'h00, 12);

    // Added key while held produces nothing; new press after release.
    v0 = nval; m0 = nmerr;
    apply(8'h02, 12);
    check("add_first", {24'd0, onehot}, 32'h02);
    apply(8'h0A, 12); apply(8'h00, 12); apply(8'h08, 12);
    check("add_nval", nval - v0, 2);
    check("add_merr", nmerr - m0, 0);
    check("add_onehot", {24'd0, onehot}, 32'h08);
    apply(8'h00, 12);

    // Table-driven patterns, each followed by a release.
    foreach (vecs[k]) begin
      v0 = nval; m0 = nmerr;
      apply(vecs[k].raw, vecs[k].hold);
      apply(8'h00, 12);
      check($sformatf("tbl%0d_nval", k), nval - v0, vecs[k].exp_val);
      check($sformatf("tbl%0d_merr", k), nmerr - m0, vecs[k].exp_merr);
      check($sformatf("tbl%0d_onehot", k), {24'd0, onehot}, {24'd0, vecs[k].exp_onehot});
    end

    // 256 presses wrap press_cnt back to 0.
    do_reset();
    v0 = nval;
    for (int i = 0; i < 256; i++) begin
      apply(8'h80, 8);
      apply(8'h00, 10);
    end
    check("wrap_nval", nval - v0, 256);
    check("wrap_pcnt", {24'd0, press_cnt}, 32'd0);
    check("wrap_onehot", {24'd0, onehot}, 32'h80);

    // Reset while a key is held: it becomes a fresh press afterwards.
    apply(8'h20, 12);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_outs", {15'd0, onehot, valid, multi_err, busy, press_cnt}, 32'd0);
    rst = 1'b0;
    vpat = '0;
    for (int i = 1; i <= 9; i++) begin
      tick(1);
      vpat[i] = valid;
    end
    check("mid_valid", {22'd0, vpat}, 32'h100);
    check("mid_onehot", {24'd0, onehot}, 32'h20);
    check("mid_pcnt", {24'd0, press_cnt}, 32'd1);
    apply(8'h00, 12);

    // Randomized traffic against the model.
    prev = 8'h00;
    for (int i = 0; i < 400; i++) begin
      logic [7:0] v;
      case ($urandom_range(0, 3))
        0: v = 8'h00;
        1: v = 8'h01 << $urandom_range(0, 7);
        2: v = 8'($urandom);
        default: v = prev;
      endcase
      prev = v;
      if ($urandom_range(0, 59) == 0) do_reset();
      apply(v, $urandom_range(1, 10));
    end
    apply(8'h00, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/onehot_key_capture.md
Name: onehot_key_capture

Overview:
- Front-end for the 8-to-3 encoder. Synchronises and debounces eight raw active-high key lines.
- Recognises single-key presses and presents each one as a registered one-hot vector with a one-cycle valid strobe.
- The encoder therefore only ever sees legal one-hot input. Multi-key chords are rejected and flagged, not passed on.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive clocks the synchronised key vector must hold unchanged before it is accepted. Legal range 2..65535.
- CNT_W, 16, width of the debounce counter. Must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- key_raw  input  8  asynchronous raw key levels, 1 = pressed
- onehot  output  8  last accepted key, one-hot; feeds encoder input
- valid  output  1  one-cycle pulse when onehot is updated with a new press
- multi_err  output  1  one-cycle pulse when a debounced press has more than one bit set
- busy  output  1  high while any debounced key is held (FSM in HELD)
- press_cnt  output  8  count of accepted single-key presses, wraps 255 -> 0

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst). On rst high at a rising edge, every register clears to 0. This covers sync stages, cand, cnt, deb, the FSM (to IDLE) and all outputs: onehot=0, valid=0, multi_err=0, busy=0, press_cnt=0. rst takes priority over all other activity.
- Synchroniser: two flops per bit, s1 <= key_raw, s2 <= s1.
- Debounce, one shared counter for the whole vector:
  - if s2 != cand: cand <= s2, cnt <= 0
  - else if cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1
  - else: deb <= cand. The counter saturates there; no further increment.
  - Any change in any bit restarts the count for the whole vector.
- FSM, states IDLE and HELD:
  - IDLE, deb == 0: stay. valid, multi_err and busy are low.
  - IDLE, deb has exactly one bit set: onehot <= deb, valid <= 1 for one cycle, press_cnt <= press_cnt+1, go to HELD.
  - IDLE, deb has two or more bits set: multi_err <= 1 for one cycle. onehot and press_cnt are unchanged. Go to HELD.
  - HELD: busy = 1. Any nonzero deb, including a different key or an added key, produces no event. When deb == 0, go to IDLE the next edge.
  - A new press is recognised only after a full debounced release.
- Latency: let key_raw change and then hold stable, with the change sampled at edge 1. Then deb updates at edge DEBOUNCE_CYCLES+3, and valid/multi_err/onehot update at edge DEBOUNCE_CYCLES+4. valid is high for exactly the one cycle that follows.
- Glitches: any raw pulse shorter than DEBOUNCE_CYCLES+1 clocks after synchronisation never reaches deb.
- onehot holds its value indefinitely between presses. It is never 0 after the first accepted press, except after reset.
- valid and multi_err are never high in the same cycle. Each press yields at most one pulse.
- press_cnt increments only on valid: 8-bit modulo, 255+1 = 0.
- Reset mid-operation: all state clears. A key still held when rst falls is treated as a fresh press and produces valid after the full latency above.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then key_raw=8'h04 held → valid high exactly one cycle, 8 edges after first sampling edge; onehot=8'h04; press_cnt=1; busy=1 until release is debounced.
- key_raw=8'h10 with a 3-cycle dropout to 0 midway, then held → single valid, onehot=8'h10; no event during dropout. A 4-clock raw glitch of 8'h01 from IDLE → no valid, onehot unchanged.
- key_raw=8'h41 held → multi_err one-cycle pulse, valid never high, onehot keeps previous value, press_cnt unchanged.
- Hold 8'h02, then add 8'h08 (8'h0A), then release to 0, then press 8'h08 → exactly two valid pulses total (onehot=8'h02, then 8'h08); no multi_err.
- 256 clean press/release cycles of 8'h80 → 256 valid pulses; press_cnt returns to 0.
- Assert rst for one cycle while 8'h20 is held and busy=1 → all outputs 0 next cycle; after rst drops, valid with onehot=8'h20 after 8 edges; press_cnt=1.
